// File: rtl/phase_sequencer_if.sv
// Handshake bundle between the normal-mode phase sequencer and its consumers
// (light-state selector, countdown display). The ped_req line exists only when
// PED_REQ_EN is defined.
interface phase_sequencer_if #(
  parameter int CNT_W = 8
) ();

  logic             run;
`ifdef PED_REQ_EN
  logic             ped_req;
`endif
  logic [1:0]       state;
  logic [CNT_W-1:0] remain;
  logic             tick;
  logic             phase_done;

  // Controller side: drives run (and ped_req), observes the phase outputs.
  modport master (
`ifdef PED_REQ_EN
    output ped_req,
`endif
    output run,
    input  state, remain, tick, phase_done
  );

  // Sequencer side.
  modport slave (
`ifdef PED_REQ_EN
    input  ped_req,
`endif
    input  run,
    output state, remain, tick, phase_done
  );

endinterface

// File: rtl/phase_sequencer.sv
// Normal-mode traffic-light phase generator: GREEN -> YELLOW -> RED -> GREEN,
// each phase lasting a whole number of 1 s ticks from a clock prescaler.
// Exports the current phase, the seconds-remaining countdown, a 1 s tick pulse
// and a phase-change pulse.
// Optional feature macro: PED_REQ_EN -- a pedestrian request during GREEN
// shortens the remaining GREEN time to PED_GREEN_SEC.
module phase_sequencer #(
  parameter int TICK_DIV      = 100_000_000,
  parameter int CNT_W         = 8,
  parameter int GREEN_SEC     = 30,
  parameter int YELLOW_SEC    = 3,
  parameter int RED_SEC       = 30,
  parameter int PED_GREEN_SEC = 5
) (
  input  logic               clk,
  input  logic               rst,
  phase_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } phase_e;

  localparam int MAX_SEC = (2 ** CNT_W) - 1;

  // Elaboration-time parameter legality.
  if (TICK_DIV < 1) begin : g_bad_div
    $error("phase_sequencer: TICK_DIV must be >= 1");
  end
  if (GREEN_SEC < 1 || GREEN_SEC > MAX_SEC) begin : g_bad_green
    $error("phase_sequencer: GREEN_SEC out of range for CNT_W");
  end
  if (YELLOW_SEC < 1 || YELLOW_SEC > MAX_SEC) begin : g_bad_yellow
    $error("phase_sequencer: YELLOW_SEC out of range for CNT_W");
  end
  if (RED_SEC < 1 || RED_SEC > MAX_SEC) begin : g_bad_red
    $error("phase_sequencer: RED_SEC out of range for CNT_W");
  end
`ifdef PED_REQ_EN
  if (PED_GREEN_SEC < 1 || PED_GREEN_SEC > GREEN_SEC) begin : g_bad_ped
    $error("phase_sequencer: PED_GREEN_SEC must be in 1..GREEN_SEC");
  end
`endif

  // Prescaler is at least one bit wide so TICK_DIV=1 still elaborates.
  localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [CNT_W-1:0] GREEN_R  = CNT_W'(GREEN_SEC);
  localparam logic [CNT_W-1:0] YELLOW_R = CNT_W'(YELLOW_SEC);
  localparam logic [CNT_W-1:0] RED_R    = CNT_W'(RED_SEC);
`ifdef PED_REQ_EN
  localparam logic [CNT_W-1:0] PED_R    = CNT_W'(PED_GREEN_SEC);
`endif

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      default: return GREEN;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] phase_len(input phase_e p);
    case (p)
      GREEN:   return GREEN_R;
      YELLOW:  return YELLOW_R;
      default: return RED_R;
    endcase
  endfunction

  phase_e            state_q, state_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
`ifdef PED_REQ_EN
  logic              ped_q, ped_d;
  logic              ped_cut;
`endif

  // Next-state logic: prescaler, countdown and phase advance.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    remain_d = remain_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
`ifdef PED_REQ_EN
    ped_d    = ped_q | ((state_q == GREEN) & bus.ped_req);
    ped_cut  = (state_q == GREEN) && (ped_q || bus.ped_req) && (remain_q > PED_R);
`endif
    if (bus.run) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (remain_q == CNT_W'(1)) begin
          state_d  = next_phase(state_q);
          remain_d = phase_len(next_phase(state_q));
          done_d   = 1'b1;
        end
`ifdef PED_REQ_EN
        else if (ped_cut) begin
          remain_d = PED_R;
        end
`endif
        else begin
          remain_d = remain_q - CNT_W'(1);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
`ifdef PED_REQ_EN
    // A pending request is consumed when GREEN ends.
    if (done_d && state_q == GREEN) begin
      ped_d = 1'b0;
    end
`endif
  end

  // State register with synchronous reset taking priority over run/ped_req.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q  <= RED;
      remain_q <= RED_R;
      presc_q  <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PED_REQ_EN
      ped_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
`ifdef PED_REQ_EN
      ped_q    <= ped_d;
`endif
    end
  end

  assign bus.state      = state_q;
  assign bus.remain     = remain_q;
  assign bus.tick       = tick_q;
  assign bus.phase_done = done_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with TICK_DIV=4, GREEN=5, YELLOW=2,
// RED=3, PED_GREEN=2. Builds with or without PED_REQ_EN.
module tb_phase_sequencer;

  localparam logic [1:0] S_RED = 2'b00;
  localparam logic [1:0] S_YEL = 2'b01;
  localparam logic [1:0] S_GRN = 2'b10;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  int n_done         = 0;
  int n_done_no_tick = 0;
  int n_bad_state    = 0;
  int n_ticks_held   = 0;

  phase_sequencer_if #(.CNT_W(8)) bus ();

  phase_sequencer #(
    .TICK_DIV      (4),
    .CNT_W         (8),
    .GREEN_SEC     (5),
    .YELLOW_SEC    (2),
    .RED_SEC       (3),
    .PED_GREEN_SEC (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advance one clock edge; outputs are sampled and inputs driven 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.phase_done) n_done++;
    if (bus.phase_done && !bus.tick) n_done_no_tick++;
    if (bus.state === 2'b11) n_bad_state++;
  endtask

  // Step until a tick is seen, bounded; returns edges taken.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.tick && n < 50);
  endtask

  task automatic expect_tick(input string tag, input logic [1:0] st, input logic [7:0] rem);
    int n;
    wait_tick(n);
    check({tag, "_tick"},  32'(bus.tick), 32'd1);
    check({tag, "_state"}, 32'(bus.state), 32'(st));
    check({tag, "_remain"}, 32'(bus.remain), 32'(rem));
  endtask

  task automatic ped_pulse();
`ifdef PED_REQ_EN
    bus.ped_req = 1'b1;
    step();
    bus.ped_req = 1'b0;
`else
    step();
`endif
  endtask

  initial begin
    int n;
    int total;
    logic [1:0] exp_st [9]  = '{S_RED, S_GRN, S_GRN, S_GRN, S_GRN, S_GRN, S_YEL, S_YEL, S_RED};
    logic [7:0] exp_rem [9] = '{8'd1, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd3};
    logic       exp_done [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst     = 1'b1;
    bus.run = 1'b0;
`ifdef PED_REQ_EN
    bus.ped_req = 1'b0;
`endif

    // 1 Reset, then run
    step();
    step();
    check("rst_state",  32'(bus.state), 32'(S_RED));
    check("rst_remain", 32'(bus.remain), 32'd3);
    check("rst_tick",   32'(bus.tick), 32'd0);
    check("rst_done",   32'(bus.phase_done), 32'd0);
    rst     = 1'b0;
    bus.run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pre_first_tick", 32'(bus.tick), 32'd0);
    end
    step();
    check("first_tick",        32'(bus.tick), 32'd1);
    check("first_tick_remain", 32'(bus.remain), 32'd2);
    check("first_tick_state",  32'(bus.state), 32'(S_RED));

    // 2 Full cycle
    n_done = 0; n_done_no_tick = 0; n_bad_state = 0;
    total  = 4;
    for (int i = 0; i < 9; i++) begin
      wait_tick(n);
      total += n;
      check("cyc_period", 32'(n), 32'd4);
      check("cyc_state",  32'(bus.state), 32'(exp_st[i]));
      check("cyc_remain", 32'(bus.remain), 32'(exp_rem[i]));
      check("cyc_done",   32'(bus.phase_done), 32'(exp_done[i]));
    end
    check("cyc_total_cycles", 32'(total), 32'd40);
    check("cyc_done_count",   32'(n_done), 32'd3);
    check("cyc_done_no_tick", 32'(n_done_no_tick), 32'd0);
    check("cyc_state_11",     32'(n_bad_state), 32'd0);

    // 3 Hold with GREEN remain=4, prescaler=2
    expect_tick("h_r2", S_RED, 8'd2);
    expect_tick("h_r1", S_RED, 8'd1);
    expect_tick("h_g5", S_GRN, 8'd5);
    expect_tick("h_g4", S_GRN, 8'd4);
    step();
    step();
    bus.run = 1'b0;
    n_ticks_held = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.tick || bus.phase_done) n_ticks_held++;
    end
    check("hold_no_tick", 32'(n_ticks_held), 32'd0);
    check("hold_state",   32'(bus.state), 32'(S_GRN));
    check("hold_remain",  32'(bus.remain), 32'd4);
    bus.run = 1'b1;
    wait_tick(n);
    check("resume_edges",  32'(n), 32'd2);
    check("resume_remain", 32'(bus.remain), 32'd3);

    // 4a Reset mid-YELLOW at remain=1, off a tick edge
    expect_tick("r_g2", S_GRN, 8'd2);
    expect_tick("r_g1", S_GRN, 8'd1);
    expect_tick("r_y2", S_YEL, 8'd2);
    expect_tick("r_y1", S_YEL, 8'd1);
    step();
    rst = 1'b1;
    step();
    check("rsta_state",  32'(bus.state), 32'(S_RED));
    check("rsta_remain", 32'(bus.remain), 32'd3);
    check("rsta_tick",   32'(bus.tick), 32'd0);
    check("rsta_done",   32'(bus.phase_done), 32'd0);
    rst = 1'b0;

    // 4b Reset on the tick edge that would end YELLOW
    for (int i = 0; i < 8; i++) wait_tick(n);
    expect_tick("rb_y1", S_YEL, 8'd1);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check("rstb_state",  32'(bus.state), 32'(S_RED));
    check("rstb_remain", 32'(bus.remain), 32'd3);
    check("rstb_tick",   32'(bus.tick), 32'd0);
    check("rstb_done",   32'(bus.phase_done), 32'd0);
    rst = 1'b0;

    // 5/6 Pedestrian request in GREEN at remain=5
    expect_tick("p_r2", S_RED, 8'd2);
    expect_tick("p_r1", S_RED, 8'd1);
    expect_tick("p_g5", S_GRN, 8'd5);
    ped_pulse();
`ifdef PED_REQ_EN
    expect_tick("p_cut", S_GRN, 8'd2);
    expect_tick("p_g1",  S_GRN, 8'd1);
`else
    expect_tick("p_g4", S_GRN, 8'd4);
    expect_tick("p_g3", S_GRN, 8'd3);
    expect_tick("p_g2", S_GRN, 8'd2);
    expect_tick("p_g1", S_GRN, 8'd1);
`endif
    expect_tick("p_y2", S_YEL, 8'd2);
    check("p_y2_done", 32'(bus.phase_done), 32'd1);
    expect_tick("p_y1", S_YEL, 8'd1);
    expect_tick("p_r3", S_RED, 8'd3);

    // Request in RED is ignored
    ped_pulse();
    expect_tick("pr_r2", S_RED, 8'd2);
    expect_tick("pr_r1", S_RED, 8'd1);
    expect_tick("pr_g5", S_GRN, 8'd5);
    expect_tick("pr_g4", S_GRN, 8'd4);
    expect_tick("pr_g3", S_GRN, 8'd3);
    expect_tick("pr_g2", S_GRN, 8'd2);

    // Request at GREEN remain=2 is too late to shorten anything
    ped_pulse();
    expect_tick("pl_g1", S_GRN, 8'd1);
    expect_tick("pl_y2", S_YEL, 8'd2);
    expect_tick("pl_y1", S_YEL, 8'd1);
    expect_tick("pl_r3", S_RED, 8'd3);
    expect_tick("pl_r2", S_RED, 8'd2);
    expect_tick("pl_r1", S_RED, 8'd1);
    expect_tick("pl_g5", S_GRN, 8'd5);
    // Pending request was cleared when GREEN ended: full decrement now.
    expect_tick("pl_g4", S_GRN, 8'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
